// File: rtl/pe_wmem_ctrl_pkg.sv
// Shared definitions for the PE weight-memory controller.
// Holds the FSM state encoding and the state-register width used by the
// controller top level.
package pe_wmem_ctrl_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_LOAD  = 3'd1;
   localparam logic [STATE_W-1:0] ST_FLUSH = 3'd2;
   localparam logic [STATE_W-1:0] ST_READ  = 3'd3;
   localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/pe_wmem_ctrl_if.sv
// Weight-stream and scratchpad-port bundle for pe_wmem_ctrl.
// Signals:
//   wgt_valid / wgt_data / wgt_ready   : incoming weight stream handshake
//   write_req_w_mem / w_addr_w_mem /
//   w_data_w_mem                       : scratchpad write port
//   read_req_w_mem / r_addr_w_mem      : read request at head of PE chain
// Modports:
//   master : controller side (drives ready and the scratchpad ports)
//   slave  : environment side (weight source and scratchpad/PE row)
interface pe_wmem_ctrl_if #(
   parameter int WMEM_ADDR_BITWIDTH = 8,
   parameter int WGT_BITWIDTH       = 8
);
   logic                          wgt_valid;
   logic [WGT_BITWIDTH-1:0]       wgt_data;
   logic                          wgt_ready;
   logic                          write_req_w_mem;
   logic [WMEM_ADDR_BITWIDTH-1:0] w_addr_w_mem;
   logic [WGT_BITWIDTH-1:0]       w_data_w_mem;
   logic                          read_req_w_mem;
   logic [WMEM_ADDR_BITWIDTH-1:0] r_addr_w_mem;

   modport master (
      input  wgt_valid, wgt_data,
      output wgt_ready, write_req_w_mem, w_addr_w_mem, w_data_w_mem,
             read_req_w_mem, r_addr_w_mem
   );

   modport slave (
      output wgt_valid, wgt_data,
      input  wgt_ready, write_req_w_mem, w_addr_w_mem, w_data_w_mem,
             read_req_w_mem, r_addr_w_mem
   );
endinterface

// File: rtl/pe_wmem_ctrl_wrap_counter.sv
// Up-counter that wraps to zero after reaching a programmable last value.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   inc        : advance by one (wraps to 0 when count == last)
//   clr        : synchronous clear, has priority over inc
//   last       : terminal value
//   count      : current value
//   wrap       : count currently equals last
module wrap_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   input  logic [WIDTH-1:0] last,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   assign wrap = (count == last);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= wrap ? '0 : count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/pe_wmem_ctrl.sv
// Weight-memory controller for a PE row.
// Loads a weight stream into consecutive scratchpad addresses, then sweeps
// read requests over the loaded range a configurable number of passes.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   start          : launch request, sampled only while idle
//   cfg_last_addr  : last scratchpad address (weight count - 1)
//   cfg_last_loop  : read passes - 1
//   cfg_skip_load  : weights already resident, go straight to reading
//   busy           : controller not idle
//   done           : one-cycle completion pulse
//   bus            : weight stream + scratchpad write/read ports
module pe_wmem_ctrl
   import pe_wmem_ctrl_pkg::*;
#(
   parameter int WMEM_ADDR_BITWIDTH = 8,
   parameter int WGT_BITWIDTH       = 8,
   parameter int LOOP_BITWIDTH      = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [WMEM_ADDR_BITWIDTH-1:0] cfg_last_addr,
   input  logic [LOOP_BITWIDTH-1:0]      cfg_last_loop,
   input  logic                          cfg_skip_load,
   output logic                          busy,
   output logic                          done,
   pe_wmem_ctrl_if.master                bus
);

   logic [STATE_W-1:0]            state;
   logic [WMEM_ADDR_BITWIDTH-1:0] last_addr_q;
   logic [LOOP_BITWIDTH-1:0]      last_loop_q;

   logic [WMEM_ADDR_BITWIDTH-1:0] wr_cnt, rd_cnt;
   logic [LOOP_BITWIDTH-1:0]      loop_cnt;
   logic                          wr_wrap, rd_wrap, loop_wrap;
   logic                          hs, rd_inc, loop_inc, clr_all, read_last;

   // wgt_ready is a pure state decode, so the handshake needs only the state.
   assign hs        = (state == ST_LOAD) && bus.wgt_valid;
   assign rd_inc    = (state == ST_READ);
   assign loop_inc  = rd_inc && rd_wrap;
   assign read_last = rd_inc && rd_wrap && loop_wrap;
   assign clr_all   = (state == ST_DONE);

   wrap_counter #(.WIDTH(WMEM_ADDR_BITWIDTH)) u_wr_cnt (
      .clk(clk), .reset(reset), .inc(hs), .clr(clr_all),
      .last(last_addr_q), .count(wr_cnt), .wrap(wr_wrap)
   );

   wrap_counter #(.WIDTH(WMEM_ADDR_BITWIDTH)) u_rd_cnt (
      .clk(clk), .reset(reset), .inc(rd_inc), .clr(clr_all),
      .last(last_addr_q), .count(rd_cnt), .wrap(rd_wrap)
   );

   wrap_counter #(.WIDTH(LOOP_BITWIDTH)) u_loop_cnt (
      .clk(clk), .reset(reset), .inc(loop_inc), .clr(clr_all),
      .last(last_loop_q), .count(loop_cnt), .wrap(loop_wrap)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         last_addr_q <= '0;
         last_loop_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  last_addr_q <= cfg_last_addr;
                  last_loop_q <= cfg_last_loop;
                  state       <= cfg_skip_load ? ST_READ : ST_LOAD;
               end
            end
            ST_LOAD:  if (hs && wr_wrap) state <= ST_FLUSH;
            // One dead cycle so the final write is on the port before any read.
            ST_FLUSH: state <= ST_READ;
            ST_READ:  if (read_last) state <= ST_DONE;
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // Write port is registered; address/data hold between writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.write_req_w_mem <= 1'b0;
         bus.w_addr_w_mem    <= '0;
         bus.w_data_w_mem    <= '0;
      end else begin
         bus.write_req_w_mem <= hs;
         if (hs) begin
            bus.w_addr_w_mem <= wr_cnt;
            bus.w_data_w_mem <= bus.wgt_data;
         end
      end
   end

   assign bus.wgt_ready      = (state == ST_LOAD);
   assign bus.read_req_w_mem = (state == ST_READ);
   assign bus.r_addr_w_mem   = rd_cnt;
   assign busy               = (state != ST_IDLE);
   assign done               = (state == ST_DONE);

endmodule

// File: tb/tb_pe_wmem_ctrl.sv
// Scoreboard bench for pe_wmem_ctrl: stimulus pushes expected writes, reads
// and done pulses (with the cycle they must appear in); a negedge monitor
// pops and compares whenever the DUT presents one.
module tb_pe_wmem_ctrl;

   typedef struct {
      int         cyc;
      logic [7:0] addr;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] cfg_last_addr;
   logic [7:0] cfg_last_loop;
   logic       cfg_skip_load;
   logic       busy;
   logic       done;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_pass = 0;

   exp_t qw[$];
   exp_t qr[$];
   int   qd[$];
   exp_t ew, er;
   int   ed;
   int   s;

   pe_wmem_ctrl_if #(.WMEM_ADDR_BITWIDTH(8), .WGT_BITWIDTH(8)) bus ();

   pe_wmem_ctrl #(
      .WMEM_ADDR_BITWIDTH(8), .WGT_BITWIDTH(8), .LOOP_BITWIDTH(8)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .cfg_last_addr(cfg_last_addr), .cfg_last_loop(cfg_last_loop),
      .cfg_skip_load(cfg_skip_load), .busy(busy), .done(done), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, int act, int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                    name, act, act, exp, exp, cyc);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_w(int c, int a, int d);
      exp_t e;
      e.cyc = c; e.addr = 8'(a); e.data = 8'(d);
      qw.push_back(e);
   endtask

   task automatic push_reads(int first, int n, int range);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.cyc = first + k; e.addr = 8'(k % range); e.data = 8'h00;
         qr.push_back(e);
      end
   endtask

   task automatic drain(string name);
      for (int i = 0; i < 60 && (qw.size() + qr.size() + qd.size()) != 0; i++) step();
      check({name, "_drain"}, qw.size() + qr.size() + qd.size(), 0);
   endtask

   task automatic check_all_zero(string name);
      check({name, "_outs"},
            int'({bus.wgt_ready, bus.write_req_w_mem, bus.read_req_w_mem, busy, done}), 0);
      check({name, "_waddr"}, bus.w_addr_w_mem, 0);
      check({name, "_wdata"}, bus.w_data_w_mem, 0);
      check({name, "_raddr"}, bus.r_addr_w_mem, 0);
   endtask

   task automatic do_start(int la, int ll, bit skip);
      cfg_last_addr = 8'(la); cfg_last_loop = 8'(ll); cfg_skip_load = skip;
      start = 1'b1;
      s = cyc;
      step();
      start = 1'b0;
   endtask

   // Monitor
   always @(negedge clk) begin
      if (bus.write_req_w_mem) begin
         if (qw.size() == 0) begin
            n_checks++;
            $display("FAIL write_unexpected: write addr %0d data 0x%0h at cycle %0d, none expected",
                     bus.w_addr_w_mem, bus.w_data_w_mem, cyc);
         end else begin
            ew = qw.pop_front();
            check("write_cycle", cyc, ew.cyc);
            check("write_addr", bus.w_addr_w_mem, ew.addr);
            check("write_data", bus.w_data_w_mem, ew.data);
         end
      end
      if (bus.read_req_w_mem) begin
         if (qr.size() == 0) begin
            n_checks++;
            $display("FAIL read_unexpected: read addr %0d at cycle %0d, none expected",
                     bus.r_addr_w_mem, cyc);
         end else begin
            er = qr.pop_front();
            check("read_cycle", cyc, er.cyc);
            check("read_addr", bus.r_addr_w_mem, er.addr);
         end
      end
      if (done) begin
         if (qd.size() == 0) begin
            n_checks++;
            $display("FAIL done_unexpected: done at cycle %0d, none expected", cyc);
         end else begin
            ed = qd.pop_front();
            check("done_cycle", cyc, ed);
         end
      end
   end

   initial begin
      reset = 1'b0; start = 1'b0;
      cfg_last_addr = 8'd0; cfg_last_loop = 8'd0; cfg_skip_load = 1'b0;
      bus.wgt_valid = 1'b0; bus.wgt_data = 8'h00;

      // Reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         start = 1'($urandom); cfg_skip_load = 1'($urandom);
         cfg_last_addr = 8'($urandom); cfg_last_loop = 8'($urandom);
         bus.wgt_valid = 1'($urandom); bus.wgt_data = 8'($urandom);
         step();
         check_all_zero("reset");
      end
      start = 1'b0; bus.wgt_valid = 1'b0;
      reset = 1'b1;
      step(); step();
      check("idle_busy", busy, 0);
      check("idle_ready", bus.wgt_ready, 0);

      // Full load: 4 weights, 2 passes
      do_start(3, 1, 1'b0);
      check("load_ready", bus.wgt_ready, 1);
      check("load_busy", busy, 1);
      for (int i = 0; i < 4; i++) begin
         bus.wgt_valid = 1'b1; bus.wgt_data = 8'(8'hA0 + i);
         push_w(s + 2 + i, i, 8'hA0 + i);
         step();
      end
      bus.wgt_valid = 1'b0;
      check("flush_ready", bus.wgt_ready, 0);
      check("flush_busy", busy, 1);
      push_reads(s + 6, 8, 4);
      qd.push_back(s + 14);
      drain("full");
      step();
      check("full_idle", busy, 0);

      // Source back-pressure: valid 1,0,1,0,1
      do_start(2, 0, 1'b0);
      bus.wgt_valid = 1'b1; bus.wgt_data = 8'hB0; push_w(s + 2, 0, 8'hB0); step();
      bus.wgt_valid = 1'b0; bus.wgt_data = 8'hFF; step();
      bus.wgt_valid = 1'b1; bus.wgt_data = 8'hB1; push_w(s + 4, 1, 8'hB1); step();
      bus.wgt_valid = 1'b0; bus.wgt_data = 8'hEE; step();
      check("bp_hold_addr", bus.w_addr_w_mem, 1);
      check("bp_hold_data", bus.w_data_w_mem, 8'hB1);
      bus.wgt_valid = 1'b1; bus.wgt_data = 8'hB2; push_w(s + 6, 2, 8'hB2); step();
      bus.wgt_valid = 1'b0;
      push_reads(s + 7, 3, 3);
      qd.push_back(s + 10);
      drain("bp");

      // Single weight, single pass
      do_start(0, 0, 1'b0);
      bus.wgt_valid = 1'b1; bus.wgt_data = 8'hC5; push_w(s + 2, 0, 8'hC5); step();
      bus.wgt_valid = 1'b0;
      check("single_flush_ready", bus.wgt_ready, 0);
      push_reads(s + 3, 1, 1);
      qd.push_back(s + 4);
      drain("single");

      // Skip load with ignored starts and valid held high
      bus.wgt_valid = 1'b1; bus.wgt_data = 8'h55;
      push_reads(s + 0, 0, 1);
      cfg_last_addr = 8'd1; cfg_last_loop = 8'd2; cfg_skip_load = 1'b1;
      start = 1'b1; s = cyc;
      push_reads(s + 1, 6, 2);
      qd.push_back(s + 7);
      for (int k = 1; k <= 8; k++) begin
         step();
         if (k == 1) start = 1'b0;
         if (k == 3) begin start = 1'b1; cfg_skip_load = 1'b0; cfg_last_addr = 8'd5; end
         if (k == 4) start = 1'b0;
         if (k == 7) start = 1'b1;
         if (k == 8) begin
            start = 1'b0;
            check("skip_done_ignores_start", busy, 0);
         end else begin
            check("skip_ready", bus.wgt_ready, 0);
         end
      end
      bus.wgt_valid = 1'b0;
      drain("skip");

      // Reset during READ, loop 1
      do_start(2, 2, 1'b1);
      push_reads(s + 1, 5, 3);
      for (int k = 2; k <= 5; k++) step();
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_all_zero("midreset");
      step(); step();
      reset = 1'b1;
      step(); step();
      check("midreset_idle", busy, 0);
      check("midreset_q", qr.size() + qd.size(), 0);
      do_start(2, 0, 1'b1);
      push_reads(s + 1, 3, 3);
      qd.push_back(s + 4);
      drain("rerun");
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
